// File: rtl/car_pkg.sv
// Shared encodings for the car simulator blocks.
package car_pkg;

  localparam int unsigned STATE_W = 4;

  // One-hot drive state encodings; the mileage recorder compares against ST_MOVING.
  localparam logic [STATE_W-1:0] ST_OFF       = 4'b1000;
  localparam logic [STATE_W-1:0] ST_NOT_START = 4'b0001;
  localparam logic [STATE_W-1:0] ST_START     = 4'b0010;
  localparam logic [STATE_W-1:0] ST_MOVING    = 4'b0100;

  typedef enum logic [STATE_W-1:0] {
    DS_OFF       = ST_OFF,
    DS_NOT_START = ST_NOT_START,
    DS_START     = ST_START,
    DS_MOVING    = ST_MOVING
  } drive_state_t;

endpackage

// File: rtl/manual_hold_timer.sv
// Saturating run-length timer: done flags the cycle that completes MAX_CYC consecutive enabled cycles.
module manual_hold_timer #(
  parameter int unsigned MAX_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYC - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last = (count == LAST);
  assign done    = en && at_last;

  // Count consecutive enabled cycles; any gap or explicit clear restarts from zero, saturate at LAST.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else if (!at_last) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual-transmission drive state sequencer with stall detection and idle auto power-off.
module manual_drive_ctrl
  import car_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned POWER_HOLD_CYC   = CLK_HZ,
  parameter int unsigned IDLE_TIMEOUT_CYC = 10 * CLK_HZ
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                power_btn,
  input  logic                power_off_btn,
  input  logic                clutch,
  input  logic                throttle,
  input  logic                brake,
  input  logic                reverse_sw,
  output logic [STATE_W-1:0]  state,
  output logic                power_on,
  output logic                reverse_mode,
  output logic                mileage_clr
);

  drive_state_t cur_state;
  drive_state_t nxt_state;
  logic         rev_nxt;
  logic         rev_prev;
  logic         state_chg;
  logic         hold_en;
  logic         hold_done;
  logic         idle_en;
  logic         idle_done;

  assign state     = STATE_W'(cur_state);
  assign state_chg = (nxt_state != cur_state);

  // Power-on hold: power_off_btn held alongside power_btn keeps the count at zero.
  assign hold_en = (cur_state == DS_OFF) && power_btn && !power_off_btn;

  // Idle: no pedal activity and the reverse selector unchanged since the previous cycle.
  assign idle_en = (cur_state == DS_NOT_START) && !clutch && !throttle && !brake &&
                   (reverse_sw == rev_prev);

  manual_hold_timer #(.MAX_CYC(POWER_HOLD_CYC)) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (hold_en),
    .clr  (state_chg),
    .done (hold_done)
  );

  manual_hold_timer #(.MAX_CYC(IDLE_TIMEOUT_CYC)) u_idle_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (idle_en),
    .clr  (state_chg),
    .done (idle_done)
  );

  // Next-state and reverse-latch decode; power-off outranks every other rule.
  always_comb begin
    nxt_state = cur_state;
    rev_nxt   = reverse_mode;
    if ((cur_state != DS_OFF) && power_off_btn) begin
      nxt_state = DS_OFF;
    end else begin
      unique case (cur_state)
        DS_OFF: begin
          if (hold_done) nxt_state = DS_NOT_START;
        end
        DS_NOT_START: begin
          rev_nxt = reverse_sw;
          if (throttle && !clutch)     nxt_state = DS_OFF;
          else if (clutch && throttle) nxt_state = DS_START;
          else if (idle_done)          nxt_state = DS_OFF;
        end
        DS_START, DS_MOVING: begin
          if (clutch) rev_nxt = reverse_sw;
          if (!clutch && (reverse_sw != reverse_mode)) begin
            nxt_state = DS_OFF;
          end else if (brake && !throttle) begin
            nxt_state = DS_NOT_START;
          end else if (cur_state == DS_START) begin
            if (!clutch && throttle && !brake) nxt_state = DS_MOVING;
          end else if (clutch || !throttle) begin
            nxt_state = DS_START;
          end
        end
        default: nxt_state = DS_OFF;
      endcase
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state    <= DS_OFF;
      power_on     <= 1'b0;
      reverse_mode <= 1'b0;
      mileage_clr  <= 1'b0;
      rev_prev     <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      power_on     <= (nxt_state != DS_OFF);
      reverse_mode <= rev_nxt;
      mileage_clr  <= (cur_state == DS_OFF) && (nxt_state == DS_NOT_START);
      rev_prev     <= reverse_sw;
    end
  end

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Scoreboard bench for manual_drive_ctrl: directed scenarios then randomized driving.
module tb_manual_drive_ctrl;

  localparam int HOLD = 4;
  localparam int IDLE = 8;

  localparam int M_OFF   = 0;
  localparam int M_NS    = 1;
  localparam int M_START = 2;
  localparam int M_MOV   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       power_btn = 1'b0;
  logic       power_off_btn = 1'b0;
  logic       clutch = 1'b0;
  logic       throttle = 1'b0;
  logic       brake = 1'b0;
  logic       reverse_sw = 1'b0;
  logic [3:0] state;
  logic       power_on;
  logic       reverse_mode;
  logic       mileage_clr;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;
  int clr_pulses = 0;

  logic [6:0] exp_q[$];

  // Reference model state: drive mode plus run lengths of held/quiet cycles.
  int m_st = M_OFF;
  int hold_run = 0;
  int quiet_run = 0;
  bit m_rev = 0;
  bit m_prev_sw = 0;
  bit m_clr = 0;

  manual_drive_ctrl #(
    .CLK_HZ(4),
    .POWER_HOLD_CYC(HOLD),
    .IDLE_TIMEOUT_CYC(IDLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .power_btn(power_btn),
    .power_off_btn(power_off_btn),
    .clutch(clutch),
    .throttle(throttle),
    .brake(brake),
    .reverse_sw(reverse_sw),
    .state(state),
    .power_on(power_on),
    .reverse_mode(reverse_mode),
    .mileage_clr(mileage_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] onehot(input int s);
    case (s)
      M_NS:    return 4'b0001;
      M_START: return 4'b0010;
      M_MOV:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Advance the model by one sampled clock edge.
  task automatic model_step(input bit r, input bit pb, input bit pob, input bit cl,
                            input bit th, input bit br, input bit rv);
    int  nst;
    bit  quiet;
    bit  nrev;
    if (!r) begin
      m_st = M_OFF; hold_run = 0; quiet_run = 0;
      m_rev = 0; m_prev_sw = 0; m_clr = 0;
    end else begin
      nst   = m_st;
      nrev  = m_rev;
      quiet = (m_st == M_NS) && !cl && !th && !br && (rv == m_prev_sw);
      if (m_st != M_OFF && pob) begin
        nst = M_OFF;
      end else if (m_st == M_OFF) begin
        if (pb && !pob && hold_run + 1 >= HOLD) nst = M_NS;
      end else if (m_st == M_NS) begin
        nrev = rv;
        if (th && !cl) nst = M_OFF;
        else if (cl && th) nst = M_START;
        else if (quiet && quiet_run + 1 >= IDLE) nst = M_OFF;
      end else begin
        if (cl) nrev = rv;
        if (!cl && rv != m_rev) nst = M_OFF;
        else if (br && !th) nst = M_NS;
        else if (m_st == M_START) begin
          if (!cl && th && !br) nst = M_MOV;
        end else if (cl || !th) nst = M_START;
      end
      if (nst != m_st) begin
        hold_run = 0; quiet_run = 0;
      end else begin
        hold_run  = (m_st == M_OFF && pb && !pob) ? hold_run + 1 : 0;
        quiet_run = quiet ? quiet_run + 1 : 0;
      end
      m_clr     = (m_st == M_OFF && nst == M_NS);
      m_st      = nst;
      m_rev     = nrev;
      m_prev_sw = rv;
    end
  endtask

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic cyc(input bit r, input bit pb, input bit pob, input bit cl,
                     input bit th, input bit br, input bit rv);
    @(negedge clk);
    rst = r; power_btn = pb; power_off_btn = pob;
    clutch = cl; throttle = th; brake = br; reverse_sw = rv;
    model_step(r, pb, pob, cl, th, br, rv);
    exp_q.push_back({onehot(m_st), m_st != M_OFF, m_rev, m_clr});
  endtask

  task automatic power_up(input bit rv);
    repeat (HOLD) cyc(1, 1, 0, 0, 0, 0, rv);
    cyc(1, 0, 0, 0, 0, 0, rv);
  endtask

  // Monitor: compare every presented output set against the queued expectation.
  initial begin
    logic [6:0] exp;
    logic [6:0] got;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {state, power_on, reverse_mode, mileage_clr};
        checks++;
        if (mileage_clr) clr_pulses++;
        if (got !== exp)
          begin
            errors++;
            $display("FAIL outputs cycle %0d: got state=%b pwr=%b rev=%b clr=%b, expected state=%b pwr=%b rev=%b clr=%b",
                     cyc_no, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
          end
      end
    end
  end

  initial begin
    int mode;
    bit rv;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 1);
    // Short hold is not enough.
    repeat (HOLD - 1) cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Power and off button together never powers on.
    repeat (HOLD + 2) cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Full hold, then launch, move, brake back to NOT_START.
    power_up(0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    // Stall in NOT_START.
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Stall in MOVING by toggling reverse without clutch.
    power_up(0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    // Reverse engaged in START with clutch held.
    power_up(1);
    cyc(1, 0, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 1, 1);
    // Idle timeout, with and without a brake tap.
    repeat (IDLE + 1) cyc(1, 0, 0, 0, 0, 0, 1);
    power_up(1);
    repeat (5) cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 1);
    repeat (IDLE + 1) cyc(1, 0, 0, 0, 0, 0, 1);
    // Power-off priority over a launch request.
    power_up(0);
    cyc(1, 0, 1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Reset in MOVING.
    power_up(0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Randomized driving in phases.
    rv = 0;
    for (int blk = 0; blk < 150; blk++) begin
      mode = $urandom_range(0, 3);
      for (int k = 0; k < 20; k++) begin
        bit r, pb, pob, cl, th, br;
        r   = ($urandom_range(0, 199) != 0);
        pob = ($urandom_range(0, 29) == 0);
        pb = 0; cl = 0; th = 0; br = 0;
        case (mode)
          0: begin pb = ($urandom_range(0, 9) != 0); end
          1: begin end
          default: begin
            pb = ($urandom_range(0, 3) == 0);
            cl = $urandom_range(0, 1);
            th = $urandom_range(0, 1);
            br = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) rv = ~rv;
          end
        endcase
        cyc(r, pb, pob, cl, th, br, rv);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    checks++;
    if (clr_pulses == 0) begin
      errors++;
      $display("FAIL mileage_clr_seen: got %0d pulses, expected at least 1", clr_pulses);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
